// File: rtl/mmio_mult_unit_pkg.sv
// Shared opcodes, status bit positions and FSM encodings for the MMIO shift-add multiplier.
package mmio_pkg;

    typedef enum logic [2:0] {
        MMIO_OP_WR_A    = 3'd0,
        MMIO_OP_WR_B    = 3'd1,
        MMIO_OP_RD_RES  = 3'd2,
        MMIO_OP_RD_STAT = 3'd3,
        MMIO_OP_NONE    = 3'd4
    } mmio_op_e;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_ERR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                                input logic ovf, input logic err);
        logic [31:0] s;
        s            = '0;
        s[STAT_BUSY] = busy;
        s[STAT_DONE] = done;
        s[STAT_OVF]  = ovf;
        s[STAT_ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/mmio_mult_unit_if.sv
// Decoder-side bus of the multiplier peripheral. o_irq exists only when MMIO_MULT_IRQ_EN is defined.
interface mmio_mult_unit_if;
    logic        i_new;
    logic [2:0]  i_opcode;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_busy;
`ifdef MMIO_MULT_IRQ_EN
    logic        o_irq;
`endif

    modport slave (
        input  i_new, i_opcode, i_wdata,
`ifdef MMIO_MULT_IRQ_EN
        output o_irq,
`endif
        output o_rdata, o_busy
    );

    modport master (
        output i_new, i_opcode, i_wdata,
`ifdef MMIO_MULT_IRQ_EN
        input  o_irq,
`endif
        input  o_rdata, o_busy
    );
endinterface

// File: rtl/mmio_mult_unit_mult_shift_core.sv
// Shift-add datapath: start loads operands, each step folds one multiplier bit into acc.
module mult_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_acc_next
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_a_sh;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;

    // Value acc takes after the current step; the owner latches it on the final step.
    assign o_acc_next = r_acc + (r_b[0] ? r_a_sh : '0);
    assign o_last     = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_a_sh <= {{WIDTH{1'b0}}, i_a};
            r_acc  <= '0;
            r_b    <= i_b;
            r_cnt  <= CW'(WIDTH);
        end else if (i_step) begin
            r_acc  <= o_acc_next;
            r_a_sh <= r_a_sh << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/mmio_mult_unit.sv
// MMIO multiplier peripheral: operand/result registers, IDLE/BUSY/DONE control and load mux.
// Optional completion interrupt enabled by defining MMIO_MULT_IRQ_EN.
module mmio_mult_unit
    import mmio_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_mult_unit_if.slave   bus
);
    mult_state_e        r_state, w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_result;
    logic               r_done, r_ovf, r_err;
    logic               w_start, w_step, w_complete, w_last;
    logic               w_wr_a, w_wr_b, w_rd_stat, w_busy;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [31:0]        w_res_ext;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_wr_a    = bus.i_new && (bus.i_opcode == MMIO_OP_WR_A);
    assign w_wr_b    = bus.i_new && (bus.i_opcode == MMIO_OP_WR_B);
    assign w_rd_stat = bus.i_new && (bus.i_opcode == MMIO_OP_RD_STAT);

    mult_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_a        (r_a),
        .i_b        (bus.i_wdata[WIDTH-1:0]),
        .o_last     (w_last),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_wr_b) begin
                    w_start      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Later assignments win: completion overrides a same-edge status-read clear of done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_a && !w_busy)
                r_a <= bus.i_wdata[WIDTH-1:0];
            if ((w_wr_a || w_wr_b) && w_busy)
                r_err <= 1'b1;
            if (w_start) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
            if (w_rd_stat) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_complete) begin
                r_result <= w_acc_next[WIDTH-1:0];
                r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
                r_done   <= 1'b1;
            end
        end
    end

`ifdef MMIO_MULT_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else if (w_complete)
            r_irq <= 1'b1;
        else if (w_start || w_rd_stat)
            r_irq <= 1'b0;
    end
    assign bus.o_irq = r_irq;
`endif

    always_comb begin
        w_res_ext              = '0;
        w_res_ext[WIDTH-1:0]   = r_result;
    end

    assign bus.o_busy  = w_busy;
    assign bus.o_rdata = (bus.i_opcode == MMIO_OP_RD_RES)  ? w_res_ext :
                         (bus.i_opcode == MMIO_OP_RD_STAT) ? pack_status(w_busy, r_done, r_ovf, r_err) :
                         32'h0;
endmodule
